gol_generation_engine: RTL and testbench

GOL_GENERATION_ENGINE -- requirements
Module: gol_generation_engine

---
 rtl/gol_generation_engine.sv | 201 ++++++++++++++++++++
 tb/tb_gol_generation_engine.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gol_generation_engine.sv
// rtl/gol_generation_engine.sv - Game-of-Life generation engine: one toroidal generation step per start request
//
// Purpose:
//   Snapshots a ROWS x COLS board, evaluates every cell one per cycle in
//   row-major order under Conway's rules with toroidal wrap, then commits the
//   new board together with birth/death/live statistics and a stability flag.
//
// Ports:
//   ClkPort         in   1          clock, all state on rising edge
//   reset_n         in   1          asynchronous active-low reset
//   enable          in   1          engine permitted to run; low aborts LOAD/SCAN
//   start           in   1          request one generation step (sampled in IDLE)
//   board_in        in   ROWS*COLS  current board, bit r*COLS+c = cell (r,c)
//   board_out       out  ROWS*COLS  last committed next-generation board
//   busy            out  1          high in every state except IDLE
//   done            out  1          one-cycle pulse when board_out is updated
//   generation_cnt  out  GEN_W      committed generations since reset
//   birth_cnt       out  9          cells born in the last committed generation
//   death_cnt       out  9          cells that died in the last committed generation
//   live_cnt        out  9          live cells in board_out
//   stable          out  1          last committed board equals its predecessor

module gol_generation_engine #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
) (
  input  logic                   ClkPort,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   board_in,
  output logic [ROWS*COLS-1:0]   board_out,
  output logic                   busy,
  output logic                   done,
  output logic [GEN_W-1:0]       generation_cnt,
  output logic [8:0]             birth_cnt,
  output logic [8:0]             death_cnt,
  output logic [8:0]             live_cnt,
  output logic                   stable
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW    = $clog2(CELLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCAN   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CELLS-1:0] cur;
  logic [CELLS-1:0] nxt;
  logic [IW-1:0]    idx;
  // row/col track idx so no divider is needed to locate the cell
  logic [RW-1:0]    row;
  logic [CW-1:0]    col;
  logic [8:0]       w_birth;
  logic [8:0]       w_death;
  logic [8:0]       w_live;

  logic [RW-1:0]    row_m, row_p;
  logic [CW-1:0]    col_m, col_p;
  logic [3:0]       nbr;
  logic             self_alive;
  logic             next_alive;
  logic             last_cell;

  function automatic logic cell_at(input logic [CELLS-1:0] b,
                                   input logic [RW-1:0]    r,
                                   input logic [CW-1:0]    c);
    logic [IW-1:0] i;
    i = IW'(r) * IW'(COLS) + IW'(c);
    return b[i];
  endfunction

  // Toroidal neighbour coordinates
  always_comb begin
    row_m = (row == '0)            ? RW'(ROWS - 1) : row - 1'b1;
    row_p = (row == RW'(ROWS - 1)) ? '0            : row + 1'b1;
    col_m = (col == '0)            ? CW'(COLS - 1) : col - 1'b1;
    col_p = (col == CW'(COLS - 1)) ? '0            : col + 1'b1;
  end

  always_comb begin
    nbr = {3'b000, cell_at(cur, row_m, col_m)}
        + {3'b000, cell_at(cur, row_m, col  )}
        + {3'b000, cell_at(cur, row_m, col_p)}
        + {3'b000, cell_at(cur, row,   col_m)}
        + {3'b000, cell_at(cur, row,   col_p)}
        + {3'b000, cell_at(cur, row_p, col_m)}
        + {3'b000, cell_at(cur, row_p, col  )}
        + {3'b000, cell_at(cur, row_p, col_p)};
    self_alive = cur[idx];
    if (self_alive) begin
      next_alive = (nbr == 4'd2) || (nbr == 4'd3);
    end else begin
      next_alive = (nbr == 4'd3);
    end
    last_cell = (idx == IW'(CELLS - 1));
  end

  always_ff @(posedge ClkPort or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && start) state_nxt = LOAD;
      LOAD:    state_nxt = enable ? SCAN : IDLE;
      SCAN: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (last_cell) begin
          state_nxt = COMMIT;
        end
      end
      // COMMIT completes regardless of enable
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge ClkPort or negedge reset_n) begin
    if (!reset_n) begin
      cur            <= '0;
      nxt            <= '0;
      idx            <= '0;
      row            <= '0;
      col            <= '0;
      w_birth        <= '0;
      w_death        <= '0;
      w_live         <= '0;
      board_out      <= '0;
      done           <= 1'b0;
      generation_cnt <= '0;
      birth_cnt      <= '0;
      death_cnt      <= '0;
      live_cnt       <= '0;
      stable         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          cur     <= board_in;
          idx     <= '0;
          row     <= '0;
          col     <= '0;
          w_birth <= '0;
          w_death <= '0;
          w_live  <= '0;
        end
        SCAN: begin
          // When aborting, the partial results are simply abandoned
          if (enable) begin
            nxt[idx] <= next_alive;
            if (next_alive) begin
              w_live <= w_live + 9'd1;
            end
            if (self_alive && !next_alive) begin
              w_death <= w_death + 9'd1;
            end
            if (!self_alive && next_alive) begin
              w_birth <= w_birth + 9'd1;
            end
            idx <= idx + 1'b1;
            if (col == CW'(COLS - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        COMMIT: begin
          board_out      <= nxt;
          birth_cnt      <= w_birth;
          death_cnt      <= w_death;
          live_cnt       <= w_live;
          stable         <= (nxt == cur);
          generation_cnt <= generation_cnt + 1'b1;
          done           <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_generation_engine.sv
// tb/tb_gol_generation_engine.sv - directed self-checking bench for gol_generation_engine

module tb_gol_generation_engine;

  logic         clk;
  logic         reset_n;
  logic         enable;
  logic         start;
  logic [255:0] board_in;
  logic [255:0] board_out;
  logic         busy;
  logic         done;
  logic [15:0]  generation_cnt;
  logic [8:0]   birth_cnt;
  logic [8:0]   death_cnt;
  logic [8:0]   live_cnt;
  logic         stable;

  int total = 0;
  int bad   = 0;

  gol_generation_engine #(.ROWS(16), .COLS(16), .GEN_W(16)) dut (
    .ClkPort        (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .start          (start),
    .board_in       (board_in),
    .board_out      (board_out),
    .busy           (busy),
    .done           (done),
    .generation_cnt (generation_cnt),
    .birth_cnt      (birth_cnt),
    .death_cnt      (death_cnt),
    .live_cnt       (live_cnt),
    .stable         (stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One generation request; edge N is where start is sampled, loop index i
  // means "just after edge N+i". board_in is scrambled from N+2 onward.
  task automatic run(input logic [255:0] b, input int restart_at, input int drop_at,
                     input int rst_at, output int done_at, output int ndone,
                     output logic busy_chk, output logic rst_zero);
    done_at  = -1;
    ndone    = 0;
    busy_chk = 1'b1;
    rst_zero = 1'b0;
    board_in = b;
    enable   = 1'b1;
    start    = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 1; i <= 262; i++) begin
      start = (i == restart_at);
      if (i >= 2) board_in = ~b;
      if (i == drop_at + 1) enable = 1'b0;
      if (i == rst_at + 1) reset_n = 1'b1;
      if (i == rst_at) begin
        reset_n = 1'b0;
        #2;
        rst_zero = (board_out == '0) && !busy && !done && (generation_cnt == '0) &&
                   (birth_cnt == '0) && (death_cnt == '0) && (live_cnt == '0) && !stable;
      end
      step(1);
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = i;
      end
      if (i == drop_at + 2) busy_chk = busy;
    end
    enable = 1'b1;
    start  = 1'b0;
  endtask

  logic [255:0] blinker, blinker_out, wrap_blk;
  int           d_at, n_d;
  logic         b_chk, r_zero;

  initial begin
    blinker = '0;
    blinker[7*16+6] = 1'b1;
    blinker[7*16+7] = 1'b1;
    blinker[7*16+8] = 1'b1;
    blinker_out = '0;
    blinker_out[6*16+7] = 1'b1;
    blinker_out[7*16+7] = 1'b1;
    blinker_out[8*16+7] = 1'b1;
    wrap_blk = '0;
    wrap_blk[0]   = 1'b1;
    wrap_blk[15]  = 1'b1;
    wrap_blk[240] = 1'b1;
    wrap_blk[255] = 1'b1;

    reset_n  = 1'b0;
    enable   = 1'b0;
    start    = 1'b0;
    board_in = '0;
    #3;
    chk("rst_board_out", board_out, '0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_done", 256'(done), 256'd0);
    chk("rst_gen", 256'(generation_cnt), 256'd0);
    chk("rst_live", 256'(live_cnt), 256'd0);
    chk("rst_stable", 256'(stable), 256'd0);
    step(2);
    reset_n = 1'b1;
    step(1);

    // start while idle but enable low is not accepted
    enable = 1'b0;
    start  = 1'b1;
    step(1);
    chk("no_enable_busy", 256'(busy), 256'd0);
    start = 1'b0;

    // blinker with a second start during the run
    run(blinker, 100, -10, -10, d_at, n_d, b_chk, r_zero);
    chk("blk_done_at", 256'(d_at), 256'd258);
    chk("blk_ndone", 256'(n_d), 256'd1);
    chk("blk_board", board_out, blinker_out);
    chk("blk_birth", 256'(birth_cnt), 256'd2);
    chk("blk_death", 256'(death_cnt), 256'd2);
    chk("blk_live", 256'(live_cnt), 256'd3);
    chk("blk_stable", 256'(stable), 256'd0);
    chk("blk_gen", 256'(generation_cnt), 256'd1);
    chk("blk_idle", 256'(busy), 256'd0);

    // abort by dropping enable mid-scan
    run(wrap_blk, -10, 50, -10, d_at, n_d, b_chk, r_zero);
    chk("abort_busy", 256'(b_chk), 256'd0);
    chk("abort_ndone", 256'(n_d), 256'd0);
    chk("abort_board", board_out, blinker_out);
    chk("abort_gen", 256'(generation_cnt), 256'd1);
    chk("abort_live", 256'(live_cnt), 256'd3);
    chk("abort_death", 256'(death_cnt), 256'd2);

    // wrapped 2x2 block across all four corners is a still life
    run(wrap_blk, -10, -10, -10, d_at, n_d, b_chk, r_zero);
    chk("wrap_done_at", 256'(d_at), 256'd258);
    chk("wrap_board", board_out, wrap_blk);
    chk("wrap_birth", 256'(birth_cnt), 256'd0);
    chk("wrap_death", 256'(death_cnt), 256'd0);
    chk("wrap_live", 256'(live_cnt), 256'd4);
    chk("wrap_stable", 256'(stable), 256'd1);
    chk("wrap_gen", 256'(generation_cnt), 256'd2);

    // empty board twice
    run('0, -10, -10, -10, d_at, n_d, b_chk, r_zero);
    chk("empty_board", board_out, '0);
    chk("empty_live", 256'(live_cnt), 256'd0);
    chk("empty_stable", 256'(stable), 256'd1);
    chk("empty_gen", 256'(generation_cnt), 256'd3);
    run('0, -10, -10, -10, d_at, n_d, b_chk, r_zero);
    chk("empty2_gen", 256'(generation_cnt), 256'd4);
    chk("empty2_ndone", 256'(n_d), 256'd1);

    // reset in the middle of a scan
    run(blinker, -10, -10, 121, d_at, n_d, b_chk, r_zero);
    chk("rstmid_zero", 256'(r_zero), 256'd1);
    chk("rstmid_ndone", 256'(n_d), 256'd0);
    chk("rstmid_gen", 256'(generation_cnt), 256'd0);

    run(blinker, -10, -10, -10, d_at, n_d, b_chk, r_zero);
    chk("post_rst_done_at", 256'(d_at), 256'd258);
    chk("post_rst_board", board_out, blinker_out);
    chk("post_rst_birth", 256'(birth_cnt), 256'd2);
    chk("post_rst_death", 256'(death_cnt), 256'd2);
    chk("post_rst_live", 256'(live_cnt), 256'd3);
    chk("post_rst_gen", 256'(generation_cnt), 256'd1);

    // horizontal-to-vertical: feeding the result back returns the original blinker
    run(blinker_out, -10, -10, -10, d_at, n_d, b_chk, r_zero);
    chk("blk2_board", board_out, blinker);
    chk("blk2_gen", 256'(generation_cnt), 256'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
